// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size/state encodings and strobe, lane-replicate and alignment helpers for mem_access_ctrl.
package mem_access_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   function automatic logic [3:0] strobe(size_e s, logic [1:0] a);
      return s == SZ_BYTE ? 4'b0001 << a : s == SZ_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
   endfunction

   function automatic logic [31:0] replicate(size_e s, logic [31:0] d);
      return s == SZ_BYTE ? {4{d[7:0]}} : s == SZ_HALF ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic misaligned(size_e s, logic [1:0] a);
      return s == SZ_RSVD || (s == SZ_HALF && a[0]) || (s == SZ_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed lane of a read word and zero/sign-extends it to 32 bits.
module load_extract
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  size_e       size,
   input  logic        sgn,
   output logic [31:0] ext
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = rdata[{addr, 3'b000} +: 8];
   assign h = addr[1] ? rdata[31:16] : rdata[15:0];
   assign ext = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store controller with byte strobes and registered load data.
// Define MEM_TIMEOUT_EN to abort an access with an error after TIMEOUT cycles without mem_ack.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata
);
   state_e            state, state_n;
   logic              we_q, sgn_q, err_q, accept, mis, tmo;
   size_e             size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, ext;

   assign mis = misaligned(size_e'(req_size), req_addr[1:0]);

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            accept  = req_valid;
            state_n = !req_valid ? IDLE : mis ? RESP : ACCESS;
         end
         ACCESS:  state_n = (mem_ack || tmo) ? RESP : ACCESS;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         sgn_q     <= 1'b0;
         err_q     <= 1'b0;
         size_q    <= SZ_BYTE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= size_e'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= mis;
         end
         if (tmo) err_q <= 1'b1;
         if (state == ACCESS && mem_ack && !we_q) rsp_rdata <= ext;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   // Counts un-acked ACCESS cycles; the last allowed one triggers the abort.
   always_ff @(posedge clk) begin
      if (!rst_n || state != ACCESS) cnt <= '0;
      else if (!mem_ack) cnt <= cnt + 1'b1;
   end
   assign tmo = state == ACCESS && !mem_ack && cnt == CW'(TIMEOUT - 1);
`else
   assign tmo = 1'b0;
`endif

   load_extract u_extract (
      .rdata(mem_rdata),
      .addr (addr_q[1:0]),
      .size (size_q),
      .sgn  (sgn_q),
      .ext  (ext)
   );

   assign req_ready = state == IDLE;
   assign mem_en    = state == ACCESS;
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wstrb = mem_we ? strobe(size_q, addr_q[1:0]) : 4'b0000;
   assign mem_wdata = replicate(size_q, wdata_q);
   assign rsp_valid = state == RESP;
   assign rsp_err   = rsp_valid & err_q;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequential load/store controller that sits directly upstream of the negedge data-holding register in the datapath. It accepts one memory request at a time, drives a word-addressed data memory with byte strobes, and waits for a memory acknowledge. Load data is aligned, sign- or zero-extended and presented on a registered 32-bit output for the holder to capture. Misaligned accesses and, optionally, memory timeouts are reported as errors.

## Interface
- ADDR_W, 32, byte-address width
- TIMEOUT, 15, max cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN)

- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address, low two bits forced 0
- mem_wstrb  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ack = 1
- mem_ack  in  1  access complete
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid: misaligned or timeout
- rsp_rdata  out  32  extended load data; held until next load completes

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid, latch all req_* fields. Aligned request goes to ACCESS. Misaligned request goes to RESP with err = 1 and never asserts mem_en. Misaligned means: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
- ACCESS: mem_en = 1; mem_we, mem_addr, mem_wstrb and mem_wdata are stable for the whole state. On mem_ack, a load latches the extracted result into rsp_rdata, then the FSM goes to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- Strobes: byte gives 4'b0001 << addr[1:0]; half gives 4'b0011 << {addr[1],1'b0}; word gives 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: select lane by addr[1:0], then zero- or sign-extend from bit 7 or 15 per req_signed.
- Stores and errored loads leave rsp_rdata unchanged.
- rsp_err is 0 on every successful completion.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, req_ready 1, mem_en/mem_we 0, mem_addr/mem_wstrb/mem_wdata 0, rsp_valid/rsp_err 0, rsp_rdata 0, timeout counter 0.
- Request accepted at edge N. mem_en is high from cycle N+1.
- If mem_ack = 1 at edge N+1 (minimum), rsp_valid is high in cycle N+2. Next accept can occur at edge N+3.
- Misaligned request accepted at edge N: rsp_valid/rsp_err high in cycle N+1.
- rsp_rdata is registered and changes only at posedge, so it is stable across the following negedge capture.
- Reset asserted mid-ACCESS: at that edge, return to IDLE with all outputs at reset values; the pending ack is discarded.
- req_valid held through RESP is not accepted until IDLE.

## Configuration
- MEM_TIMEOUT_EN defined: a counter increments each ACCESS cycle without ack. When the count reaches TIMEOUT, the FSM goes to RESP with rsp_err = 1, drops mem_en, and leaves rsp_rdata unchanged.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for mem_ack.

## Structure
- Package mem_access_pkg: size encodings, FSM state encoding, strobe/lane-replicate functions.
- One combinational sub-module, load_extract: takes rdata, addr[1:0], size and signed; returns the extended 32-bit value.

## Test plan
- Word load at 0x100, mem_rdata 0xDEADBEEF, ack after 2 wait cycles -> mem_addr 0x100, wstrb 0000, rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid one cycle.
- Signed byte load at 0x103, mem_rdata 0x80FF7F01 -> rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0x1234ABCD at 0x22 -> mem_addr 0x20, wstrb 1100, mem_wdata 0xABCDABCD, mem_we 1; rsp_rdata unchanged.
- Word load at 0x101 -> no mem_en, rsp_valid and rsp_err 1 one cycle after accept.
- With MEM_TIMEOUT_EN, TIMEOUT 15, ack never asserted -> rsp_err 1 after 15 ACCESS cycles, mem_en low afterward.
- rst_n low during ACCESS, then ack -> no rsp_valid; req_ready 1 the cycle after reset releases.
